// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic-array drain stages.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Signed add clamped to a width-bit two's complement range (width <= 62).
  function automatic logic signed [63:0] sat_add(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int                 width
  );
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/col_accum_ram.sv
// Per-column partial-sum buffer: one synchronous write port, one combinational read port.
module col_accum_ram #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pe_col_accum.sv
// Drain stage below a PE column: accumulates bottom-PE partial sums across K-tiles
// and streams the finished sums out over valid/ready on the last tile.
module pe_col_accum
  import systolic_pkg::*;
#(
  parameter  int SUM_BITWIDTH  = 16,
  parameter  int ACC_BITWIDTH  = 32,
  parameter  int ACC_DEPTH     = 16,
  parameter  int TILE_BITWIDTH = 8,
  localparam int ADDR_W        = $clog2(ACC_DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_start,
  input  logic [ADDR_W:0]                i_cfg_rows,
  input  logic [TILE_BITWIDTH-1:0]       i_cfg_tiles,
  input  logic                           i_in_valid,
  input  logic signed [SUM_BITWIDTH-1:0] i_in_sum,
  output logic                           o_in_ready,
  output logic                           o_out_valid,
  output logic [ACC_BITWIDTH-1:0]        o_out_data,
  output logic                           o_out_last,
  input  logic                           i_out_ready,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_err_drop
);

  state_e                     r_state, w_state_next;
  logic [ADDR_W-1:0]          r_ptr;
  logic [TILE_BITWIDTH-1:0]   r_tile;
  logic [TILE_BITWIDTH-1:0]   r_tiles;
  logic [ADDR_W:0]            r_rows;
  logic                       r_out_valid;
  logic                       r_out_last;
  logic [ACC_BITWIDTH-1:0]    r_out_data;
  logic                       r_done;
  logic                       r_err_drop;

  logic                       w_cfg_ok;
  logic                       w_start_ok;
  logic                       w_last_tile;
  logic                       w_last_row;
  logic                       w_in_ready;
  logic                       w_accept;
  logic                       w_out_hs;
  logic                       w_ram_we;
  logic signed [ACC_BITWIDTH-1:0] w_sext;
  logic signed [ACC_BITWIDTH-1:0] w_rd_data;
  logic signed [ACC_BITWIDTH-1:0] w_value;

  assign w_cfg_ok    = (i_cfg_rows != '0) && (i_cfg_rows <= (ADDR_W+1)'(ACC_DEPTH)) &&
                       (i_cfg_tiles != '0);
  assign w_start_ok  = i_start && (r_state == IDLE) && w_cfg_ok;
  assign w_last_tile = (r_tile == r_tiles - TILE_BITWIDTH'(1));
  assign w_last_row  = ({1'b0, r_ptr} == r_rows - (ADDR_W+1)'(1));
  // On the last tile the single output register must be free or draining this cycle.
  assign w_in_ready  = (r_state == ACCUM) && (!w_last_tile || !r_out_valid || i_out_ready);
  assign w_accept    = i_in_valid && w_in_ready;
  assign w_out_hs    = r_out_valid && i_out_ready;
  assign w_ram_we    = w_accept && !w_last_tile;

  assign w_sext  = ACC_BITWIDTH'(i_in_sum);
  assign w_value = (r_tile == '0) ? w_sext
                 : ACC_BITWIDTH'(sat_add(64'(w_rd_data), 64'(w_sext), ACC_BITWIDTH));

  col_accum_ram #(
    .DEPTH (ACC_DEPTH),
    .WIDTH (ACC_BITWIDTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (r_ptr),
    .i_wdata (w_value),
    .i_raddr (r_ptr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start_ok) w_state_next = ACCUM;
      ACCUM:   if (w_accept && w_last_tile && w_last_row) w_state_next = DRAIN;
      DRAIN:   if (w_out_hs) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_tile      <= '0;
      r_tiles     <= '0;
      r_rows      <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_done      <= 1'b0;
      r_err_drop  <= 1'b0;
    end else begin
      r_done <= (r_state == DRAIN) && w_out_hs;

      if (w_start_ok) begin
        r_rows     <= i_cfg_rows;
        r_tiles    <= i_cfg_tiles;
        r_ptr      <= '0;
        r_tile     <= '0;
        r_err_drop <= 1'b0;
      end else begin
        if (i_in_valid && !w_in_ready) r_err_drop <= 1'b1;
        if (w_accept) begin
          if (w_last_row) begin
            r_ptr  <= '0;
            r_tile <= r_tile + TILE_BITWIDTH'(1);
          end else begin
            r_ptr <= r_ptr + ADDR_W'(1);
          end
        end
      end

      // A new load wins over a concurrent handshake so there is no bubble.
      if (w_accept && w_last_tile) begin
        r_out_data  <= w_value;
        r_out_valid <= 1'b1;
        r_out_last  <= w_last_row;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_last  = r_out_last;
  assign o_busy      = (r_state != IDLE);
  assign o_done      = r_done;
  assign o_err_drop  = r_err_drop;

endmodule

// File: tb/tb_pe_col_accum.sv
// Self-checking bench for pe_col_accum: vector table, corner sequences and randomized jobs.
module tb_pe_col_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [4:0]  i_cfg_rows = '0;
  logic [7:0]  i_cfg_tiles = '0;
  logic        i_in_valid = 1'b0;
  logic [15:0] i_in_sum = '0;
  logic        i_out_ready = 1'b0;

  logic        o_in_ready, o_out_valid, o_out_last, o_busy, o_done, o_err_drop;
  logic [31:0] o_out_data;
  logic        o_in_ready16, o_out_valid16, o_out_last16, o_busy16, o_done16, o_err_drop16;
  logic [15:0] o_out_data16;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int g_sums[$];

  always #5 clk = ~clk;

  pe_col_accum dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_cfg_rows(i_cfg_rows),
    .i_cfg_tiles(i_cfg_tiles), .i_in_valid(i_in_valid), .i_in_sum(i_in_sum),
    .o_in_ready(o_in_ready), .o_out_valid(o_out_valid), .o_out_data(o_out_data),
    .o_out_last(o_out_last), .i_out_ready(i_out_ready), .o_busy(o_busy),
    .o_done(o_done), .o_err_drop(o_err_drop)
  );

  pe_col_accum #(.ACC_BITWIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_cfg_rows(i_cfg_rows),
    .i_cfg_tiles(i_cfg_tiles), .i_in_valid(i_in_valid), .i_in_sum(i_in_sum),
    .o_in_ready(o_in_ready16), .o_out_valid(o_out_valid16), .o_out_data(o_out_data16),
    .o_out_last(o_out_last16), .i_out_ready(i_out_ready), .o_busy(o_busy16),
    .o_done(o_done16), .o_err_drop(o_err_drop16)
  );

  task automatic check(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  function automatic longint clamp(input longint v, input int w);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one job from g_sums (tile-major order) and checks every cycle against a model.
  task automatic run_job(input int rows, input int tiles, input bit use16, input int rdy_pct,
                         input int spur_at, output longint first_v, output longint last_v);
    longint exp_q[$];
    longint acc, act;
    bit     pend, exp_rdy, ov, ol;
    int     idx, oidx, cyc, n, w;
    pend = 0; idx = 0; oidx = 0; cyc = 0;
    n = rows * tiles;
    w = use16 ? 16 : 32;
    first_v = 0; last_v = 0;
    for (int r = 0; r < rows; r++) begin
      acc = 0;
      for (int t = 0; t < tiles; t++)
        acc = (t == 0) ? longint'(g_sums[t*rows+r]) : clamp(acc + g_sums[t*rows+r], w);
      exp_q.push_back(acc);
    end

    i_cfg_rows = 5'(rows); i_cfg_tiles = 8'(tiles);
    i_start = 1; i_in_valid = 0; i_out_ready = 0;
    step();
    i_start = 0;
    check("busy_after_start", o_busy, 1);

    while (oidx < rows && cyc < 3000) begin
      i_in_valid  = 0;
      i_out_ready = ($urandom_range(0, 99) < rdy_pct);
      i_start     = (idx == spur_at);
      if (idx == spur_at) begin
        i_cfg_rows = 5'd1; i_cfg_tiles = 8'd1;
      end
      #1;
      exp_rdy = (idx < n) && ((idx < rows * (tiles - 1)) || !pend || i_out_ready);
      ov = use16 ? o_out_valid16 : o_out_valid;
      ol = use16 ? o_out_last16 : o_out_last;
      check("in_ready", o_in_ready, exp_rdy);
      check("out_valid", ov, pend);
      i_in_valid = exp_rdy;
      i_in_sum   = (idx < n) ? 16'(g_sums[idx]) : 16'h0;
      if (pend) begin
        act = use16 ? longint'($signed(o_out_data16)) : longint'($signed(o_out_data));
        check("out_data", act, exp_q[oidx]);
        check("out_last", ol, (oidx == rows - 1));
        if (i_out_ready) begin
          if (oidx == 0) first_v = act;
          if (oidx == rows - 1) last_v = act;
          oidx++;
          pend = 0;
        end
      end
      if (exp_rdy) begin
        if (idx >= rows * (tiles - 1)) pend = 1;
        idx++;
      end
      step();
      cyc++;
    end
    i_in_valid = 0; i_out_ready = 0; i_start = 0;
    check("job_outputs_seen", oidx, rows);
    check("done_pulse", o_done, 1);
    check("busy_end", o_busy, 0);
    check("err_drop_clear", o_err_drop, 0);
    step();
    check("done_low", o_done, 0);
    $display("job rows=%0d tiles=%0d acc%0d first=%0d last=%0d cycles=%0d",
             rows, tiles, w, first_v, last_v, cyc);
  endtask

  typedef struct {
    int     rows;
    int     tiles;
    bit     use16;
    int     base;
    int     stp;
    longint exp_first;
    longint exp_last;
  } vec_t;

  vec_t vecs[7];

  initial begin
    longint f, l;

    vecs[0] = '{4, 3, 1'b0, 1, 1, 3, 12};
    vecs[1] = '{1, 4, 1'b0, -5, 0, -20, -20};
    vecs[2] = '{1, 3, 1'b1, 32767, 0, 32767, 32767};
    vecs[3] = '{1, 3, 1'b1, -32768, 0, -32768, -32768};
    vecs[4] = '{3, 1, 1'b0, 7, 1, 7, 9};
    vecs[5] = '{16, 2, 1'b0, 100, -13, 200, -190};
    vecs[6] = '{2, 5, 1'b1, 20000, -30000, 32767, -32768};

    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", o_busy, 0);
    check("rst_out_valid", o_out_valid, 0);
    check("rst_out_data", o_out_data, 0);
    check("rst_out_last", o_out_last, 0);
    check("rst_done", o_done, 0);
    check("rst_err_drop", o_err_drop, 0);
    check("rst_in_ready", o_in_ready, 0);
    rst_n = 1;
    step();

    for (int i = 0; i < 7; i++) begin
      g_sums.delete();
      for (int t = 0; t < vecs[i].tiles; t++)
        for (int r = 0; r < vecs[i].rows; r++)
          g_sums.push_back(vecs[i].base + vecs[i].stp * r);
      run_job(vecs[i].rows, vecs[i].tiles, vecs[i].use16, 100, -1, f, l);
      check($sformatf("vec%0d_first", i), f, vecs[i].exp_first);
      check($sformatf("vec%0d_last", i), l, vecs[i].exp_last);
    end

    // Output stall with single-tile job: input held while blocked must not be lost.
    i_cfg_rows = 5'd2; i_cfg_tiles = 8'd1; i_start = 1;
    step();
    i_start = 0;
    i_in_valid = 1; i_in_sum = 16'h1234; i_out_ready = 0;
    #1;
    check("stall_first_ready", o_in_ready, 1);
    step();
    i_in_sum = 16'hFFFE;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("stall_in_ready", o_in_ready, 0);
      check("stall_out_valid", o_out_valid, 1);
      check("stall_out_data", o_out_data, 32'h0000_1234);
      step();
    end
    check("stall_err_drop", o_err_drop, 1);
    i_out_ready = 1;
    #1;
    check("release_in_ready", o_in_ready, 1);
    step();
    i_in_valid = 0;
    #1;
    check("release_out_data", o_out_data, 32'hFFFF_FFFE);
    check("release_out_last", o_out_last, 1);
    check("release_out_valid", o_out_valid, 1);
    step();
    check("stall_done", o_done, 1);
    check("stall_busy", o_busy, 0);
    check("stall_out_valid_clr", o_out_valid, 0);
    i_out_ready = 0;
    step();
    check("err_drop_sticky", o_err_drop, 1);
    $display("stall sequence complete");

    // Illegal configurations leave the stage idle.
    i_cfg_rows = 5'd0; i_cfg_tiles = 8'd2; i_start = 1;
    step();
    i_start = 0;
    check("bad_rows0_busy", o_busy, 0);
    i_cfg_rows = 5'd2; i_cfg_tiles = 8'd0; i_start = 1;
    step();
    i_start = 0;
    check("bad_tiles0_busy", o_busy, 0);
    i_cfg_rows = 5'd17; i_cfg_tiles = 8'd1; i_start = 1;
    step();
    i_start = 0;
    check("bad_rows17_busy", o_busy, 0);

    // Start pulse mid-job must not disturb the running job.
    g_sums = '{5, 6, 7, 8};
    run_job(2, 2, 1'b0, 100, 1, f, l);
    check("spur_start_first", f, 12);
    check("spur_start_last", l, 14);

    // Reset during tile 1 of 3 aborts immediately.
    i_cfg_rows = 5'd2; i_cfg_tiles = 8'd3; i_start = 1;
    step();
    i_start = 0;
    i_out_ready = 1;
    for (int b = 0; b < 3; b++) begin
      i_in_valid = 1; i_in_sum = 16'(b + 1);
      #1;
      check("pre_reset_ready", o_in_ready, 1);
      step();
    end
    i_in_valid = 0;
    #1;
    check("pre_reset_busy", o_busy, 1);
    check("pre_reset_data", o_out_data, 32'd14);
    rst_n = 0;
    #1;
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_in_ready", o_in_ready, 0);
    check("mid_rst_out_valid", o_out_valid, 0);
    check("mid_rst_out_data", o_out_data, 0);
    check("mid_rst_out_data16", o_out_data16, 0);
    check("mid_rst_done", o_done, 0);
    i_out_ready = 0;
    step();
    rst_n = 1;
    step();
    g_sums.delete();
    for (int k = 0; k < 6; k++) g_sums.push_back(int'($urandom_range(0, 65535)) - 32768);
    run_job(2, 3, 1'b0, 80, -1, f, l);

    for (int j = 0; j < 8; j++) begin
      int rows, tiles;
      rows  = int'($urandom_range(1, 16));
      tiles = int'($urandom_range(1, 5));
      g_sums.delete();
      for (int k = 0; k < rows * tiles; k++)
        g_sums.push_back(int'($urandom_range(0, 65535)) - 32768);
      run_job(rows, tiles, j[0], 70, -1, f, l);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
